// File: rtl/gc_led_pkg.sv
// gc_led_display shared types and constants.
// GC_LED_PEAK_HOLD_EN adds the PEAK display mode.
package gc_led_pkg;

  typedef enum logic [2:0] {
    MODE_BUTTONS = 3'd0,
    MODE_JOY     = 3'd1,
    MODE_CSTICK  = 3'd2,
    MODE_TRIG    = 3'd3,
    MODE_PEAK    = 3'd4
  } mode_e;

  localparam int BTN_A       = 0;
  localparam int BTN_B       = 1;
  localparam int BTN_X       = 2;
  localparam int BTN_Y       = 3;
  localparam int BTN_START   = 4;
  localparam int BTN_L       = 5;
  localparam int BTN_R       = 6;
  localparam int BTN_Z       = 7;
  localparam int BTN_D_UP    = 8;
  localparam int BTN_D_DOWN  = 9;
  localparam int BTN_D_RIGHT = 10;
  localparam int BTN_D_LEFT  = 11;

`ifdef GC_LED_PEAK_HOLD_EN
  localparam int NUM_MODES = 5;
`else
  localparam int NUM_MODES = 4;
`endif

  localparam mode_e MODE_LAST = mode_e'(3'(NUM_MODES - 1));

  function automatic int unsigned centre(input int unsigned fw);
    return 32'd1 << (fw - 1);
  endfunction

endpackage

// File: rtl/gc_led_display_button_debounce.sv
// Mode push-button: 2-FF sync, stable-count debounce,
// one-cycle pulse on each debounced press.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_adv
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_deb;
  logic          r_deb_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync  <= '0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_deb_d <= r_deb;
      if (r_sync[1] == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_cnt <= '0;
        r_deb <= ~r_deb;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_adv = r_deb & ~r_deb_d;

endmodule

// File: rtl/gc_led_display.sv
// Run-time selectable LED viewer for GameCube controller polls.
// GC_LED_PEAK_HOLD_EN enables trigger peak-hold mode.
module gc_led_display
  import gc_led_pkg::*;
#(
  parameter int FIELD_W         = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MOVE_THRESH     = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [11:0]          buttons,
  input  logic [FIELD_W-1:0]   joy_x,
  input  logic [FIELD_W-1:0]   joy_y,
  input  logic [FIELD_W-1:0]   c_x,
  input  logic [FIELD_W-1:0]   c_y,
  input  logic [FIELD_W-1:0]   l_trig,
  input  logic [FIELD_W-1:0]   r_trig,
  input  logic                 sample_valid,
  input  logic                 mode_btn,
  output logic [2*FIELD_W-1:0] leds,
  output logic [2:0]           mode
);

  localparam int W1 = FIELD_W + 1;
  localparam logic [FIELD_W:0] CTR = W1'(centre(FIELD_W));
  localparam logic [FIELD_W:0] THR = W1'(MOVE_THRESH);

  logic                 w_adv;
  mode_e                r_mode;
  mode_e                w_mode_nxt;
  logic [11:0]          r_btn;
  logic [FIELD_W-1:0]   r_jx, r_jy, r_cx, r_cy;
  logic [FIELD_W-1:0]   r_lt, r_rt;
  logic [2*FIELD_W-1:0] r_leds;
  logic [2*FIELD_W-1:0] w_leds;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk  (clk),
    .reset(reset),
    .i_btn(mode_btn),
    .o_adv(w_adv)
  );

  function automatic logic moved(
    input logic [FIELD_W-1:0] v
  );
    logic [FIELD_W:0] e;
    logic [FIELD_W:0] d;
    e = {1'b0, v};
    d = (e >= CTR) ? e - CTR : CTR - e;
    return d > THR;
  endfunction

  always_comb begin
    w_mode_nxt = r_mode;
    if (w_adv) begin
      w_mode_nxt = (r_mode == MODE_LAST) ?
        MODE_BUTTONS : mode_e'(r_mode + 3'd1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode <= MODE_BUTTONS;
      r_btn  <= '0;
      r_jx   <= '0;
      r_jy   <= '0;
      r_cx   <= '0;
      r_cy   <= '0;
      r_lt   <= '0;
      r_rt   <= '0;
      r_leds <= '0;
    end else begin
      r_mode <= w_mode_nxt;
      r_leds <= w_leds;
      if (sample_valid) begin
        r_btn <= buttons;
        r_jx  <= joy_x;
        r_jy  <= joy_y;
        r_cx  <= c_x;
        r_cy  <= c_y;
        r_lt  <= l_trig;
        r_rt  <= r_trig;
      end
    end
  end

`ifdef GC_LED_PEAK_HOLD_EN
  logic [FIELD_W-1:0] r_pl, r_pr;
  logic               w_clr;

  // Clear wins over max; a coincident sample seeds the peak.
  always_comb begin
    w_clr = (w_mode_nxt == MODE_PEAK && r_mode != MODE_PEAK) ||
            (sample_valid && buttons[BTN_START] &&
             r_mode == MODE_PEAK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pl <= '0;
      r_pr <= '0;
    end else if (w_clr) begin
      r_pl <= sample_valid ? l_trig : '0;
      r_pr <= sample_valid ? r_trig : '0;
    end else if (sample_valid) begin
      if (l_trig > r_pl) r_pl <= l_trig;
      if (r_trig > r_pr) r_pr <= r_trig;
    end
  end
`endif

  always_comb begin
    w_leds = '0;
    unique case (r_mode)
      MODE_BUTTONS: begin
        w_leds[11:0] = r_btn;
        w_leds[12]   = moved(r_jx);
        w_leds[13]   = moved(r_jy);
        w_leds[14]   = moved(r_cx);
        w_leds[15]   = moved(r_cy);
      end
      MODE_JOY:    w_leds = {r_jy, r_jx};
      MODE_CSTICK: w_leds = {r_cy, r_cx};
      MODE_TRIG:   w_leds = {r_lt, r_rt};
`ifdef GC_LED_PEAK_HOLD_EN
      MODE_PEAK:   w_leds = {r_pl, r_pr};
`endif
      default:     w_leds = '0;
    endcase
  end

  assign leds = r_leds;
  assign mode = r_mode;

endmodule

// File: tb/tb_gc_led_display.sv
// Scoreboard bench for gc_led_display against a
// behavioural model of the display rules.
module tb_gc_led_display;

  localparam int FW = 8;
  localparam int DB = 16;
  localparam int TH = 24;
`ifdef GC_LED_PEAK_HOLD_EN
  localparam int NM = 5;
`else
  localparam int NM = 4;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] buttons = '0;
  logic [7:0]  joy_x = '0, joy_y = '0, c_x = '0, c_y = '0;
  logic [7:0]  l_trig = '0, r_trig = '0;
  logic        sample_valid = 1'b0;
  logic        mode_btn = 1'b0;
  logic [15:0] leds;
  logic [2:0]  mode;

  gc_led_display #(
    .FIELD_W(FW),
    .DEBOUNCE_CYCLES(DB),
    .MOVE_THRESH(TH)
  ) dut (
    .clk(clk), .reset(reset), .buttons(buttons),
    .joy_x(joy_x), .joy_y(joy_y), .c_x(c_x), .c_y(c_y),
    .l_trig(l_trig), .r_trig(r_trig),
    .sample_valid(sample_valid), .mode_btn(mode_btn),
    .leds(leds), .mode(mode)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [15:0] leds;
    logic [2:0]  mode;
    int          tag;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;

  int m_btn, m_jx, m_jy, m_cx, m_cy, m_lt, m_rt;
  int m_mode, m_pl, m_pr;

  function automatic int mv(input int v);
    int d;
    d = v - 128;
    if (d < 0) d = -d;
    return (d > TH) ? 1 : 0;
  endfunction

  function automatic logic [15:0] model_leds();
    case (m_mode)
      0: return 16'(m_btn | (mv(m_jx) << 12) | (mv(m_jy) << 13)
                 | (mv(m_cx) << 14) | (mv(m_cy) << 15));
      1: return 16'(m_jy * 256 + m_jx);
      2: return 16'(m_cy * 256 + m_cx);
      3: return 16'(m_lt * 256 + m_rt);
      4: return 16'(m_pl * 256 + m_pr);
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_btn = 0; m_jx = 0; m_jy = 0; m_cx = 0; m_cy = 0;
    m_lt = 0; m_rt = 0; m_mode = 0; m_pl = 0; m_pr = 0;
  endtask

  task automatic push(input int dly, input int tag);
    exp_t e;
    e.at = cyc + dly;
    e.leds = model_leds();
    e.mode = 3'(m_mode);
    e.tag = tag;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      exp_t e;
      e = sbq.pop_front();
      total++;
      if (e.at != cyc) begin
        bad++;
        $display("FAIL tag%0d late: due=%0d now=%0d", e.tag, e.at, cyc);
      end else if (leds !== e.leds || mode !== e.mode) begin
        bad++;
        $display("FAIL tag%0d got leds=%h mode=%0d want leds=%h mode=%0d",
                 e.tag, leds, mode, e.leds, e.mode);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a poll onto the inputs and fold it into the model.
  task automatic drive(input logic [11:0] b,
                       input logic [7:0] jx, jy, cx, cy, lt, rt);
    buttons = b; joy_x = jx; joy_y = jy; c_x = cx; c_y = cy;
    l_trig = lt; r_trig = rt; sample_valid = 1'b1;
    if (NM == 5 && m_mode == 4 && b[4]) begin
      m_pl = lt; m_pr = rt;
    end else begin
      if (lt > m_pl) m_pl = lt;
      if (rt > m_pr) m_pr = rt;
    end
    m_btn = b; m_jx = jx; m_jy = jy; m_cx = cx; m_cy = cy;
    m_lt = lt; m_rt = rt;
  endtask

  task automatic sample(input logic [11:0] b,
                        input logic [7:0] jx, jy, cx, cy, lt, rt,
                        input int tag);
    drive(b, jx, jy, cx, cy, lt, rt);
    push(2, tag);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic press(input int hold, input int tag);
    mode_btn = 1'b1;
    repeat (hold) tick();
    mode_btn = 1'b0;
    repeat (40) tick();
    if (hold >= DB + 4) begin
      m_mode = (m_mode + 1) % NM;
      if (m_mode == 4) begin m_pl = 0; m_pr = 0; end
    end
    push(1, tag);
    tick();
  endtask

  task automatic drain(input int tag);
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 20) begin tick(); n++; end
    if (sbq.size() > 0) begin
      total++; bad++;
      $display("FAIL tag%0d drain: pending=%0d want 0", tag, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    bit got;
    model_reset();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    push(1, 0);
    tick();

    sample(12'hA5A, 8'd152, 8'd128, 8'd128, 8'd128, 8'd0, 8'd0, 1);
    sample(12'hA5A, 8'd153, 8'd128, 8'd128, 8'd128, 8'd0, 8'd0, 2);
    sample(12'h5A5, 8'd103, 8'd128, 8'd128, 8'd128, 8'd0, 8'd0, 3);
    repeat (3) tick();

    press(10, 4);
    press(40, 5);

    joy_x = 8'h3C;
    tick();
    push(2, 6);
    repeat (3) tick();
    sample(12'h001, 8'h3C, 8'h77, 8'd9, 8'd8, 8'd1, 8'd2, 7);
    repeat (3) tick();

    sample(12'h003, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8);
    drain(9);
    reset = 1'b0;
    #2;
    total++;
    if (leds !== 16'h0 || mode !== 3'd0) begin
      bad++;
      $display("FAIL async_reset got leds=%h mode=%0d want leds=0 mode=0",
               leds, mode);
    end
    model_reset();
    tick();
    tick();
    reset = 1'b1;
    tick();
    push(1, 10);
    tick();

    for (int i = 0; i < 5; i++) press(40, 11 + i);

    if (NM == 5) begin
      for (int i = 0; i < 5 && m_mode != 4; i++) press(40, 20);
      sample(12'h000, 8'd1, 8'd1, 8'd1, 8'd1, 8'd5, 8'd40, 21);
      sample(12'h000, 8'd1, 8'd1, 8'd1, 8'd1, 8'd3, 8'd200, 22);
      sample(12'h000, 8'd1, 8'd1, 8'd1, 8'd1, 8'd9, 8'd90, 23);
      sample(12'h010, 8'd1, 8'd1, 8'd1, 8'd1, 8'd4, 8'd17, 24);
      repeat (3) tick();
    end

    for (int i = 0; i < 6 && m_mode != 2; i++) press(40, 25);
    drain(26);
    mode_btn = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (dut.w_adv) got = 1'b1;
    end
    if (got) begin
      drive(12'(12'h0FF & 12'($urandom)), 8'($urandom), 8'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      m_mode = 3;
      push(2, 27);
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
    end else begin
      total++; bad++;
      $display("FAIL adv_wait got timeout want adv pulse");
    end
    mode_btn = 1'b0;
    repeat (40) tick();

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) press(40, 30);
      sample(12'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), 8'($urandom), 8'($urandom), 31);
      repeat ($urandom_range(0, 2)) tick();
    end

    drain(32);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
